seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised multi-cycle successor to the 16-bit combinational ALU in the single-cycle MIPS datapath.
- Keeps the existing ALUControl encodings for single-cycle ops.
- Adds iterative unsigned multiply and divide with a HI/LO result pair, a start/done handshake, and signed-correct overflow and SLT.
- Sits in the EX stage of the multi-cycle CPU; the control FSM stalls on busy.

Parameters:
- WIDTH, 16, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- alu_control  input  4  operation code, sampled on accept.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- busy  output  1  high from accept edge until done cycle ends.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- result_lo  output  WIDTH  primary result / product low / quotient.
- result_hi  output  WIDTH  product high / remainder; 0 for single-cycle ops.
- zero  output  1  result_lo == 0.
- overflow  output  1  signed overflow on add/sub; 0 otherwise.
- div_by_zero  output  1  divu with b == 0.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counter 0. Takes effect immediately at any point, including mid-operation; the in-flight op is discarded with no done pulse.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: busy=1, done=1.
- Accept: start=1 in IDLE at edge k.
- start in RUN or DONE is ignored; it is not queued.
- Single-cycle ops:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND.
  - Result registered at edge k; IDLE→DONE.
  - done is high in the cycle after edge k (latency 1).
- Iterative ops:
  - 1000 MULTU: shift-add, {hi,lo} = a*b, 2*WIDTH-bit unsigned.
  - 1001 DIVU: restoring division, lo = a/b, hi = a%b.
  - Edge k loads operands and sets counter=WIDTH; IDLE→RUN.
  - Each RUN edge performs one iteration and decrements the counter. The edge performing the final iteration (k+WIDTH) moves to DONE.
  - done is high in the cycle after edge k+WIDTH (latency WIDTH+1).
- DONE→IDLE unconditionally on the next edge. A new start is accepted in the first IDLE cycle, so back-to-back issue occurs every 2 cycles for single-cycle ops.
- Outputs hold their values after done until the next accept edge updates them. Single-cycle ops update them at edge k; iterative ops update them at edge k+WIDTH. Intermediate values are never visible on the outputs.
- ADD/SUB: wrap modulo 2^WIDTH. overflow = operand signs match (B inverted for SUB) and result sign differs.
- SLT: result_lo = 1 iff signed a < b, computed as sign(a-b) XOR overflow (correct at extremes).
- DIVU with b=0: lo = all ones, hi = a, div_by_zero=1. Full WIDTH+1 latency is still used.
- Undefined alu_control: all results 0, zero=1, latency 1.
- zero, overflow and div_by_zero are registered together with result_lo.

Decomposition:
- Shared header alu_defs.vh: ALUControl opcode localparams (existing seven plus MULTU/DIVU) and FSM state encodings. The CPU control unit includes the same header.
- One sub-module, iter_muldiv:
  - Holds the shift registers, counter, and add/subtract datapath for MULTU/DIVU.
  - Interface: load, op, last, hi, lo.
- seq_alu owns the FSM, the single-cycle logic and the output registers.

Test Plan (WIDTH=16):
- ADD a=0x7FFF, b=0x0001 → result_lo=0x8000, overflow=1, zero=0, done one cycle after accept.
- SUB 5−5 → result_lo=0, zero=1. SLT a=0x8000, b=0x0001 → result_lo=1. SLT a=0x0001, b=0x8000 → result_lo=0.
- MULTU 0xFFFF×0xFFFF → hi=0xFFFE, lo=0x0001. done exactly 17 cycles after accept edge; busy=1 throughout. A start pulsed mid-run is ignored.
- DIVU 100/7 → lo=14, hi=2, div_by_zero=0. DIVU 5/0 → lo=0xFFFF, hi=5, div_by_zero=1, latency 17.
- Assert rst_n=0 five cycles into MULTU → outputs 0 and busy=0 immediately. No done pulse follows. Next start is accepted normally.
- Back-to-back: AND 0xF0F0&0x0FF0, then NAND with start held high continuously → AND result 0x00F0 and NAND result 0xFF0F, with each op's done two cycles apart.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: ALUControl opcodes and FSM states.
// The CPU control unit imports the same package so encodings stay in one place.
package seq_alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_NAND  = 4'b1101;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_iter(input logic [3:0] op);
        return (op == ALU_MULTU) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/seq_alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// hi/lo present the state *after* the current iteration, so they are final when last=1.
module iter_muldiv #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             op,      // 0: MULTU, 1: DIVU
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic             op_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff, div_hi, div_lo;
    logic             div_ge;

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi    = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};

        // The true difference fits in WIDTH bits whenever it is kept, so a WIDTH-bit subtract suffices.
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_hi    = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_lo    = {lo_q[WIDTH-2:0], div_ge};

        hi        = op_q ? div_hi : mul_hi;
        lo        = op_q ? div_lo : mul_lo;
        last      = (cnt_q == CNT_W'(1));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            op_q   <= 1'b0;
            cnt_q  <= '0;
        end else if (load) begin
            hi_q   <= '0;
            lo_q   <= a;
            opnd_q <= b;
            op_q   <= op;
            cnt_q  <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            hi_q   <= hi;
            lo_q   <= lo;
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: single-cycle logic ops plus iterative MULTU/DIVU,
// with a start/busy/done handshake and registered results.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    state_e           state;
    logic             dz_q;
    logic             accept, md_load, md_last;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] sum, diff, sc_lo;
    logic             ovf_add, ovf_sub, sc_ovf;

    assign accept  = (state == S_IDLE) && start;
    assign md_load = accept && is_iter(alu_control);

    iter_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (md_load),
        .op    (alu_control == ALU_DIVU),
        .a     (a),
        .b     (b),
        .last  (md_last),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // SLT uses sign(a-b) XOR overflow so it stays correct at the signed extremes.
    always_comb begin
        sum     = a + b;
        diff    = a - b;
        ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        sc_lo   = '0;
        sc_ovf  = 1'b0;
        case (alu_control)
            ALU_AND:  sc_lo = a & b;
            ALU_OR:   sc_lo = a | b;
            ALU_ADD:  begin sc_lo = sum;  sc_ovf = ovf_add; end
            ALU_SUB:  begin sc_lo = diff; sc_ovf = ovf_sub; end
            ALU_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
            ALU_NOR:  sc_lo = ~(a | b);
            ALU_NAND: sc_lo = ~(a & b);
            default:  ;
        endcase
    end

    // NOTE: every register, including the result outputs, is cleared by reset so an aborted op leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && is_iter(alu_control)) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        dz_q  <= (alu_control == ALU_DIVU) && (b == '0);
                    end else if (start) begin
                        state       <= S_DONE;
                        busy        <= 1'b1;
                        done        <= 1'b1;
                        result_lo   <= sc_lo;
                        result_hi   <= '0;
                        zero        <= (sc_lo == '0);
                        overflow    <= sc_ovf;
                        div_by_zero <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (md_last) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        result_lo   <= md_lo;
                        result_hi   <= md_hi;
                        zero        <= (md_lo == '0);
                        overflow    <= 1'b0;
                        div_by_zero <= dz_q;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=16) with hand-computed expectations.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [3:0]  alu_control;
    logic [15:0] a, b;
    logic        busy, done, zero, overflow, div_by_zero;
    logic [15:0] result_lo, result_hi;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
        .a(a), .b(b), .busy(busy), .done(done), .result_lo(result_lo),
        .result_hi(result_hi), .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    // Called at a falling edge; returns at the falling edge just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] xa, input logic [15:0] xb);
        alu_control = op; a = xa; b = xb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycles from the accept edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; alu_control = 4'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, result_lo, result_hi, zero, overflow, div_by_zero} !== 37'b0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b lo=%h hi=%h z=%b ov=%b dz=%b, want all 0",
                     busy, done, result_lo, result_hi, zero, overflow, div_by_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat;
        issue(ALU_ADD, 16'h7FFF, 16'h0001);
        wait_done(lat);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL add_latency: got %0d want 1", lat); end
        checks++;
        if ({result_lo, result_hi, overflow, zero} !== {16'h8000, 16'h0000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL add_result: got lo=%h hi=%h ov=%b z=%b want lo=8000 hi=0000 ov=1 z=0",
                     result_lo, result_hi, overflow, zero);
        end
        @(negedge clk);
    endtask

    task automatic test_sub_slt();
        int lat;
        issue(ALU_SUB, 16'd5, 16'd5);
        wait_done(lat);
        checks++;
        if ({result_lo, zero, overflow, lat} !== {16'h0000, 1'b1, 1'b0, 32'd1}) begin
            failures++;
            $display("FAIL sub_zero: got lo=%h z=%b ov=%b lat=%0d want lo=0000 z=1 ov=0 lat=1",
                     result_lo, zero, overflow, lat);
        end
        @(negedge clk);
        issue(ALU_SUB, 16'h8000, 16'h0001);
        wait_done(lat);
        checks++;
        if ({result_lo, overflow, zero} !== {16'h7FFF, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub_overflow: got lo=%h ov=%b z=%b want lo=7fff ov=1 z=0", result_lo, overflow, zero);
        end
        @(negedge clk);
        issue(ALU_SLT, 16'h8000, 16'h0001);
        wait_done(lat);
        checks++;
        if ({result_lo, overflow} !== {16'h0001, 1'b0}) begin
            failures++;
            $display("FAIL slt_neg_lt_pos: got lo=%h ov=%b want lo=0001 ov=0", result_lo, overflow);
        end
        @(negedge clk);
        issue(ALU_SLT, 16'h0001, 16'h8000);
        wait_done(lat);
        checks++;
        if ({result_lo, zero} !== {16'h0000, 1'b1}) begin
            failures++;
            $display("FAIL slt_pos_lt_neg: got lo=%h z=%b want lo=0000 z=1", result_lo, zero);
        end
        @(negedge clk);
        issue(ALU_OR, 16'h1200, 16'h0034);
        wait_done(lat);
        checks++;
        if ({result_lo, zero} !== {16'h1234, 1'b0}) begin
            failures++;
            $display("FAIL or_result: got lo=%h z=%b want lo=1234 z=0", result_lo, zero);
        end
        @(negedge clk);
        issue(4'b0011, 16'h00FF, 16'h0F0F);
        wait_done(lat);
        checks++;
        if ({result_lo, result_hi, zero, overflow, lat} !== {16'h0000, 16'h0000, 1'b1, 1'b0, 32'd1}) begin
            failures++;
            $display("FAIL undefined_op: got lo=%h hi=%h z=%b ov=%b lat=%0d want lo=0 hi=0 z=1 ov=0 lat=1",
                     result_lo, result_hi, zero, overflow, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_multu();
        int lat;
        issue(ALU_MULTU, 16'hFFFF, 16'hFFFF);
        lat = 1;
        while (!done && lat < 40) begin
            checks++;
            if (busy !== 1'b1) begin failures++; $display("FAIL multu_busy: cycle %0d got busy=%b want 1", lat, busy); end
            if (lat == 8) begin
                checks++;
                if ({result_lo, result_hi} !== 32'h0) begin
                    failures++;
                    $display("FAIL multu_hidden: got lo=%h hi=%h mid-run want previous 0000/0000", result_lo, result_hi);
                end
            end
            // A start pulsed mid-run must not be queued or disturb the latched operands.
            if (lat == 5) begin
                start = 1'b1; alu_control = ALU_ADD; a = 16'h0001; b = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) lat = -1;
        checks++;
        if (lat !== 17) begin failures++; $display("FAIL multu_latency: got %0d want 17", lat); end
        checks++;
        if ({result_hi, result_lo, busy, zero, overflow} !== {16'hFFFE, 16'h0001, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL multu_result: got hi=%h lo=%h busy=%b z=%b ov=%b want hi=fffe lo=0001 busy=1 z=0 ov=0",
                     result_hi, result_lo, busy, zero, overflow);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, result_hi, result_lo} !== {1'b0, 1'b0, 16'hFFFE, 16'h0001}) begin
            failures++;
            $display("FAIL multu_hold: got done=%b busy=%b hi=%h lo=%h want done=0 busy=0 hi=fffe lo=0001",
                     done, busy, result_hi, result_lo);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL multu_no_queue: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_divu();
        int lat;
        issue(ALU_DIVU, 16'd100, 16'd7);
        wait_done(lat);
        checks++;
        if ({result_lo, result_hi, div_by_zero, lat} !== {16'd14, 16'd2, 1'b0, 32'd17}) begin
            failures++;
            $display("FAIL divu_100_7: got lo=%0d hi=%0d dz=%b lat=%0d want lo=14 hi=2 dz=0 lat=17",
                     result_lo, result_hi, div_by_zero, lat);
        end
        @(negedge clk);
        issue(ALU_DIVU, 16'd5, 16'd0);
        wait_done(lat);
        checks++;
        if ({result_lo, result_hi, div_by_zero, lat} !== {16'hFFFF, 16'd5, 1'b1, 32'd17}) begin
            failures++;
            $display("FAIL divu_by_zero: got lo=%h hi=%h dz=%b lat=%0d want lo=ffff hi=0005 dz=1 lat=17",
                     result_lo, result_hi, div_by_zero, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int lat;
        int spurious = 0;
        issue(ALU_MULTU, 16'h1234, 16'h0003);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result_lo, result_hi, div_by_zero, zero} !== 36'b0) begin
            failures++;
            $display("FAIL reset_midop: got busy=%b done=%b lo=%h hi=%h dz=%b z=%b want all 0",
                     busy, done, result_lo, result_hi, div_by_zero, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) spurious++;
        end
        checks++;
        if (spurious !== 0) begin failures++; $display("FAIL reset_no_done: got %0d done cycles want 0", spurious); end
        issue(ALU_ADD, 16'd2, 16'd3);
        wait_done(lat);
        checks++;
        if ({result_lo, lat} !== {16'd5, 32'd1}) begin
            failures++;
            $display("FAIL reset_recover: got lo=%h lat=%0d want lo=0005 lat=1", result_lo, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        alu_control = ALU_AND; a = 16'hF0F0; b = 16'h0FF0; start = 1'b1;
        @(negedge clk);
        checks++;
        if ({done, result_lo} !== {1'b1, 16'h00F0}) begin
            failures++;
            $display("FAIL b2b_and: got done=%b lo=%h want done=1 lo=00f0", done, result_lo);
        end
        alu_control = ALU_NAND;
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_gap: got done=%b busy=%b want 0 0", done, busy);
        end
        @(negedge clk);
        checks++;
        if ({done, result_lo} !== {1'b1, 16'hFF0F}) begin
            failures++;
            $display("FAIL b2b_nand: got done=%b lo=%h want done=1 lo=ff0f", done, result_lo);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_multu();
        test_divu();
        test_reset_midop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
